// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants and response-tag layout for the two-requester BRAM port arbiter.
package bram_port_arbiter_pkg;

    localparam logic ID_M0     = 1'b0;
    localparam logic ID_M1     = 1'b1;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    typedef struct packed {
        logic vld;
        logic id;
    } rsp_tag_t;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Single-word request port: req/gnt handshake in, per-requester read-valid strobe out.
interface bram_port_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
);
    logic             req;
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    logic             gnt;
    logic             rvalid;

    modport master (output req, we, addr, wdata, input gnt, rvalid);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid);
endinterface

// File: rtl/bram_port_arbiter_rr_arb2.sv
// Two-way combinational grant with last-grant memory; zero latency, gnt low during reset.
module rr_arb2
    import bram_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       mode,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // Contention: round-robin favours whoever did not win last.
                2'b11:   gnt = (mode == ARB_RR && last_q == ID_M0) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept) last_d = gnt[1];
    end

    always_ff @(posedge clk) begin
        if (rst) last_q <= ID_M1;
        else     last_q <= last_d;
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between m0/m1; one request per cycle, reads return 2 cycles after accept.
// Backpressure is only the combinational gnt; a requester holds req until granted.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    parameter  int RR_EN = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    bram_port_arbiter_if.slave m0,
    bram_port_arbiter_if.slave m1,
    output logic [WIDTH-1:0]  rdata,
    output logic              bram_ce,
    output logic              bram_we,
    output logic [AW-1:0]     bram_addr,
    output logic [WIDTH-1:0]  bram_d,
    input  logic [WIDTH-1:0]  bram_q
);

    localparam logic ARB_MODE = (RR_EN != 0) ? ARB_RR : ARB_FIXED;

    logic [1:0]       gnt;
    logic             accept;
    logic             win_id;
    logic             win_we;
    logic             ce_d, ce_q;
    logic             we_d, we_q;
    logic [AW-1:0]    addr_d, addr_q;
    logic [WIDTH-1:0] d_d, d_q;
    rsp_tag_t         s1_d, s1_q, s2_q;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({m1.req, m0.req}),
        .mode   (ARB_MODE),
        .accept (accept),
        .gnt    (gnt)
    );

    assign accept = |gnt;
    assign win_id = gnt[1] ? ID_M1 : ID_M0;
    assign win_we = gnt[1] ? m1.we : m0.we;

    always_comb begin
        ce_d   = 1'b0;
        we_d   = 1'b0;
        addr_d = addr_q;
        d_d    = d_q;
        s1_d   = '0;
        if (accept) begin
            ce_d     = 1'b1;
            we_d     = win_we;
            addr_d   = gnt[1] ? m1.addr  : m0.addr;
            d_d      = gnt[1] ? m1.wdata : m0.wdata;
            s1_d.vld = ~win_we;
            s1_d.id  = win_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ce_q   <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            d_q    <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
        end else begin
            ce_q   <= ce_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            d_q    <= d_d;
            s1_q   <= s1_d;
            s2_q   <= s1_q;
        end
    end

    assign bram_ce   = ce_q;
    assign bram_we   = we_q;
    assign bram_addr = addr_q;
    assign bram_d    = d_q;
    assign rdata     = bram_q;

    assign m0.gnt    = gnt[0];
    assign m1.gnt    = gnt[1];
    // Stage 2 lines up with the cycle in which bram_q carries the read word.
    assign m0.rvalid = s2_q.vld & (s2_q.id == ID_M0);
    assign m1.rvalid = s2_q.vld & (s2_q.id == ID_M1);

endmodule
